// File: rtl/cov_rd_stream.sv
// Read-streaming stage: sequential RAM reads, latency-absorbing FIFO, valid/ready stream out.
// Optional stall counter output enabled by defining COV_RD_STREAM_STALL_CNT_EN.
module cov_rd_stream #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int RD_LAT = 1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [ADDR_W-1:0] base_adr_i,
  input  logic [15:0]       len_i,
  output logic              ram_rd_en_o,
  output logic [ADDR_W-1:0] adr_o,
  input  logic [DATA_W-1:0] ram_dout_i,
  output logic [DATA_W-1:0] s_data_o,
  output logic              s_valid_o,
  input  logic              s_ready_i,
  output logic              busy_o,
  output logic              done_o
`ifdef COV_RD_STREAM_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt_o
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [15:0]       rd_left_q, rd_left_d;
  logic [15:0]       acc_left_q, acc_left_d;
  logic [RD_LAT-1:0] vld_pipe_q, vld_pipe_d;
  logic [PW-1:0]     wptr_q, rptr_q;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [CW:0]       inflight;
  logic [CW:0]       occ;
  logic              credit_ok;
  logic              flush;
  logic              push, push_en, pop;

  // Reads still travelling through the RAM pipe hold a FIFO slot in advance.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++)
      inflight = inflight + {{CW{1'b0}}, vld_pipe_q[i]};
  end

  assign occ         = {1'b0, cnt_q} + inflight;
  assign credit_ok   = occ < DEPTH_C;
  assign flush       = abort_i && (state_q != IDLE);
  assign ram_rd_en_o = (state_q == FETCH) && credit_ok;
  assign adr_o       = adr_q;
  assign s_valid_o   = (cnt_q != '0);
  assign s_data_o    = s_valid_o ? mem_q[rptr_q] : '0;
  assign pop         = s_valid_o && s_ready_i;
  assign push        = vld_pipe_q[RD_LAT-1];
  assign push_en     = push && !flush;
  assign busy_o      = (state_q == FETCH) || (state_q == DRAIN);
  assign done_o      = (state_q == DONE);

  always_comb begin
    state_d    = state_q;
    adr_d      = adr_q;
    rd_left_d  = rd_left_q;
    acc_left_d = acc_left_q;
    if (pop) acc_left_d = acc_left_q - 16'd1;
    unique case (state_q)
      IDLE: begin
        if (start_i && !abort_i) begin
          adr_d      = base_adr_i;
          rd_left_d  = len_i;
          acc_left_d = len_i;
          state_d    = (len_i == 16'd0) ? DONE : FETCH;
        end
      end
      FETCH: begin
        if (ram_rd_en_o) begin
          adr_d     = adr_q + 1'b1;
          rd_left_d = rd_left_q - 16'd1;
          if (rd_left_q == 16'd1) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && acc_left_q == 16'd1) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_comb begin
    vld_pipe_d    = vld_pipe_q << 1;
    vld_pipe_d[0] = ram_rd_en_o;
    if (flush) vld_pipe_d = '0;
  end

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push_en, pop && !flush})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    if (flush) cnt_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q    <= IDLE;
      adr_q      <= '0;
      rd_left_q  <= '0;
      acc_left_q <= '0;
      vld_pipe_q <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      adr_q      <= adr_d;
      rd_left_q  <= rd_left_d;
      acc_left_q <= acc_left_d;
      vld_pipe_q <= vld_pipe_d;
      cnt_q      <= cnt_d;
      if (flush) begin
        wptr_q <= '0;
        rptr_q <= '0;
      end else begin
        if (push) wptr_q <= wptr_q + 1'b1;
        if (pop)  rptr_q <= rptr_q + 1'b1;
      end
    end
  end

  // Storage is not reset; occupancy alone decides what is visible.
  always_ff @(posedge clk_i) begin
    if (push_en) mem_q[wptr_q] <= ram_dout_i;
  end

`ifdef COV_RD_STREAM_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (state_q == IDLE && start_i && !abort_i)
      stall_d = '0;
    else if (s_valid_o && !s_ready_i && stall_q != 16'hFFFF)
      stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) stall_q <= '0;
    else          stall_q <= stall_d;
  end

  assign stall_cnt_o = stall_q;
`endif

endmodule

// File: tb/tb_cov_rd_stream.sv
// Bench for cov_rd_stream: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_cov_rd_stream;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int DEPTH = 4;
  localparam int RD_LAT = 1;
  localparam int M_IDLE = 0, M_FETCH = 1, M_DRAIN = 2, M_DONE = 3;
  localparam int R_ONE = 0, R_RAND = 1, R_FORCE = 2, R_TOGGLE = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0, start = 1'b0, abort = 1'b0, s_ready = 1'b0;
  logic [AW-1:0] base = '0;
  logic [15:0]   len = '0;
  logic          rd_en, s_valid, busy, done;
  logic [AW-1:0] adr;
  logic [DW-1:0] ram_dout = '0, s_data;
`ifdef COV_RD_STREAM_STALL_CNT_EN
  logic [15:0]   stall_cnt;
`endif

  int n_assert = 0, n_fail = 0, cyc = 0;
  int ready_mode = R_ONE;
  bit ready_force = 1'b0;

  // reference model state: plain queues and counters
  int          m_mode = M_IDLE, m_rleft = 0, m_aleft = 0, m_stall = 0;
  logic [31:0] m_adr = '0;
  logic [31:0] m_fifo[$];
  logic [31:0] m_idata[$];
  int          m_idue[$];
  bit          mrd, mhs;

  // observation logs of DUT activity
  logic [31:0] rd_adr[$];
  int          rd_cyc[$];
  logic [31:0] acc_data[$];
  int          acc_cyc[$];
  int          done_cyc[$];

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return a ^ 32'hDEADBEEF;
  endfunction

  function automatic bit m_rd();
    return (m_mode == M_FETCH) && ((m_fifo.size() + m_idata.size()) < DEPTH);
  endfunction

  cov_rd_stream #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
    .clk_i(clk), .reset_i(rst_n), .start_i(start), .abort_i(abort),
    .base_adr_i(base), .len_i(len), .ram_rd_en_o(rd_en), .adr_o(adr),
    .ram_dout_i(ram_dout), .s_data_o(s_data), .s_valid_o(s_valid),
    .s_ready_i(s_ready), .busy_o(busy), .done_o(done)
`ifdef COV_RD_STREAM_STALL_CNT_EN
    , .stall_cnt_o(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // single-cycle-latency RAM
  always @(posedge clk) if (rd_en) ram_dout <= mem_f(adr);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // model advances on each edge using the inputs presented before it
  initial forever begin
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      m_mode = M_IDLE; m_adr = '0; m_stall = 0;
      m_fifo.delete(); m_idata.delete(); m_idue.delete();
    end else begin
      mrd = m_rd();
      mhs = (m_fifo.size() > 0) && s_ready;
      if (m_mode == M_IDLE && start && !abort) m_stall = 0;
      else if (m_fifo.size() > 0 && !s_ready && m_stall < 65535) m_stall++;
      if (abort && m_mode != M_IDLE) begin
        m_mode = M_IDLE;
        m_fifo.delete(); m_idata.delete(); m_idue.delete();
      end else begin
        if (mhs) begin void'(m_fifo.pop_front()); m_aleft--; end
        while (m_idue.size() > 0 && m_idue[0] == cyc) begin
          m_fifo.push_back(m_idata.pop_front());
          void'(m_idue.pop_front());
        end
        if (mrd) begin m_idata.push_back(mem_f(m_adr)); m_idue.push_back(cyc + RD_LAT); end
        case (m_mode)
          M_IDLE: if (start && !abort) begin
            m_adr = base; m_rleft = int'(len); m_aleft = int'(len);
            m_mode = (len == 0) ? M_DONE : M_FETCH;
          end
          M_FETCH: if (mrd) begin
            m_adr++; m_rleft--;
            if (m_rleft == 0) m_mode = M_DRAIN;
          end
          M_DRAIN: if (m_aleft == 0) m_mode = M_DONE;
          default: m_mode = M_IDLE;
        endcase
      end
    end
  end

  // compare and log mid-cycle
  initial forever begin
    @(negedge clk);
    if (cyc > 0) begin
      chk("rd_en", rd_en, m_rd());
      if (m_rd()) chk("adr", adr, m_adr);
      chk("busy", busy, (m_mode == M_FETCH) || (m_mode == M_DRAIN));
      chk("done", done, m_mode == M_DONE);
      chk("s_valid", s_valid, m_fifo.size() > 0);
      if (m_fifo.size() > 0) chk("s_data", s_data, m_fifo[0]);
`ifdef COV_RD_STREAM_STALL_CNT_EN
      chk("stall_cnt", stall_cnt, m_stall);
`endif
      if (rd_en) begin rd_adr.push_back(adr); rd_cyc.push_back(cyc); end
      if (s_valid && s_ready) begin acc_data.push_back(s_data); acc_cyc.push_back(cyc); end
      if (done) done_cyc.push_back(cyc);
    end
  end

  initial forever begin
    @(posedge clk); #1;
    case (ready_mode)
      R_ONE:    s_ready = 1'b1;
      R_RAND:   s_ready = ($urandom_range(0, 3) != 0);
      R_FORCE:  s_ready = ready_force;
      default:  s_ready = ~s_ready;
    endcase
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic clear_logs();
    rd_adr.delete(); rd_cyc.delete(); acc_data.delete(); acc_cyc.delete(); done_cyc.delete();
  endtask

  // s = index of the edge that samples start
  task automatic do_start(input logic [31:0] b, input logic [15:0] l, output int s);
    base = b; len = l; start = 1'b1; s = cyc + 1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    int k;
    k = 0;
    while (!done && k < budget) begin tick(); k++; end
    chk(nm, done, 1'b1);
    tick();
  endtask

  logic [31:0] exp3 [4];
  int s;

  initial begin
    repeat (3) tick();
    chk("rst_adr", adr, 32'h0);
    chk("rst_s_data", s_data, 32'h0);
    chk("rst_rd_en", rd_en, 1'b0);
    rst_n = 1'b1;
    tick();

    // 1: base 0x10, len 8, always ready
    clear_logs();
    do_start(32'h10, 16'd8, s);
    wait_done("t1_done_seen", 60);
    chk("t1_nreads", rd_adr.size(), 8);
    for (int i = 0; i < 8; i++) begin
      chk("t1_adr", rd_adr[i], 32'h10 + i);
      chk("t1_rd_cyc", rd_cyc[i], s + i);
      chk("t1_acc_cyc", acc_cyc[i], s + 2 + i);
    end
    chk("t1_first_data", acc_data[0], 32'hDEADBEFF);
    chk("t1_last_data", acc_data[7], 32'hDEADBEF8);
    chk("t1_done_cyc", done_cyc[0], acc_cyc[7] + 1);

    // 2: len 6 with a 10-cycle stall
    clear_logs();
    ready_force = 1'b0; ready_mode = R_FORCE;
    do_start(32'h100, 16'd6, s);
    repeat (10) tick();
    chk("t2_reads_in_stall", rd_adr.size(), DEPTH);
    chk("t2_none_accepted", acc_data.size(), 0);
    ready_force = 1'b1;
    wait_done("t2_done_seen", 60);
    chk("t2_nacc", acc_data.size(), 6);
    for (int i = 0; i < 6; i++) chk("t2_data", acc_data[i], (32'h100 + i) ^ 32'hDEADBEEF);
    ready_mode = R_ONE;

    // 3: address wrap
    clear_logs();
    exp3 = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0, 32'h1};
    do_start(32'hFFFFFFFE, 16'd4, s);
    wait_done("t3_done_seen", 60);
    for (int i = 0; i < 4; i++) chk("t3_adr", rd_adr[i], exp3[i]);
    chk("t3_wrap_data", acc_data[2], 32'hDEADBEEF);

    // 4: zero length
    clear_logs();
    do_start(32'h55, 16'd0, s);
    repeat (4) tick();
    chk("t4_no_reads", rd_adr.size(), 0);
    chk("t4_one_done", done_cyc.size(), 1);
    chk("t4_done_cyc", done_cyc[0], s);

    // 5: abort on the third handshake, then a fresh transfer
    clear_logs();
    do_start(32'h200, 16'd8, s);
    repeat (4) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t5_valid_after_abort", s_valid, 1'b0);
    chk("t5_acc_before_abort", acc_data.size(), 3);
    repeat (10) tick();
    chk("t5_no_done", done_cyc.size(), 0);
    chk("t5_idle", busy, 1'b0);
    clear_logs();
    do_start(32'h300, 16'd3, s);
    wait_done("t5_restart_done", 60);
    chk("t5_restart_n", acc_data.size(), 3);
    chk("t5_restart_data", acc_data[0], 32'hDEADBDEF);

    // 6: start while busy is ignored
    clear_logs();
    do_start(32'h40, 16'd5, s);
    tick();
    base = 32'h80; len = 16'd2; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("t6_done_seen", 60);
    chk("t6_nreads", rd_adr.size(), 5);
    chk("t6_last_adr", rd_adr[4], 32'h44);
    chk("t6_nacc", acc_data.size(), 5);
    chk("t6_one_done", done_cyc.size(), 1);

    // 7: abort and start together in idle
    clear_logs();
    base = 32'h90; len = 16'd3; start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    repeat (3) tick();
    chk("t7_not_busy", busy, 1'b0);
    chk("t7_no_reads", rd_adr.size(), 0);

    // 8: alternating ready (stall counter tracked by the model)
    clear_logs();
    ready_mode = R_TOGGLE;
    do_start(32'h500, 16'd8, s);
    wait_done("t8_done_seen", 80);
    chk("t8_nacc", acc_data.size(), 8);
    chk("t8_last_data", acc_data[7], 32'h507 ^ 32'hDEADBEEF);

    // randomized traffic with sporadic abort, start-while-busy and reset
    ready_mode = R_RAND;
    for (int t = 0; t < 60; t++) begin
      int k;
      logic [31:0] b;
      b = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF0 + $urandom_range(0, 15)) : $urandom;
      do_start(b, 16'($urandom_range(0, 12)), s);
      k = 0;
      while ((busy || done) && k < 300) begin
        abort = ($urandom_range(0, 39) == 0);
        start = ($urandom_range(0, 29) == 0);
        base  = $urandom;
        len   = 16'($urandom_range(0, 12));
        rst_n = ($urandom_range(0, 149) != 0);
        tick();
        k++;
      end
      abort = 1'b0; start = 1'b0; rst_n = 1'b1;
      chk("rand_finished", busy, 1'b0);
      repeat ($urandom_range(1, 3)) tick();
    end

    ready_mode = R_ONE;
    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
